// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/subtract with the carry chain split across STAGES registered slices
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    logic             adv;
    logic             v  [STAGES];
    logic [WIDTH-1:0] ar [STAGES];
    logic [WIDTH-1:0] br [STAGES];
    logic [WIDTH-1:0] sr [STAGES];
    logic             cr [STAGES];
    logic             xv [STAGES];
    logic [WIDTH-1:0] xa [STAGES];
    logic [WIDTH-1:0] xb [STAGES];
    logic [WIDTH-1:0] xs [STAGES];
    logic             xc [STAGES];
    logic [WIDTH-1:0] ns [STAGES];
    logic             nc [STAGES];
    logic [S:0]       t;
    logic             ovf_r;
    logic             zero_r;
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = v[L];
    assign sum       = sr[L];
    assign co        = cr[L];
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    // stage inputs: stage 0 takes the new operation (b pre-inverted for subtract), others the previous register
    always_comb begin
        xv[0] = in_valid;
        xa[0] = a;
        xb[0] = b ^ {WIDTH{sub}};
        xs[0] = '0;
        xc[0] = sub;
        for (int i = 1; i < STAGES; i++) begin
            xv[i] = v[i-1];
            xa[i] = ar[i-1];
            xb[i] = br[i-1];
            xs[i] = sr[i-1];
            xc[i] = cr[i-1];
        end
    end
    always_comb begin
        t = '0;
        for (int i = 0; i < STAGES; i++) begin
            t = {1'b0, xa[i][i*S +: S]} + {1'b0, xb[i][i*S +: S]} + (S+1)'(xc[i]);
            ns[i] = xs[i];
            ns[i][i*S +: S] = t[S-1:0];
            nc[i] = t[S];
        end
    end
    // carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                v[i]  <= 1'b0;
                ar[i] <= '0;
                br[i] <= '0;
                sr[i] <= '0;
                cr[i] <= 1'b0;
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                v[i]  <= xv[i];
                ar[i] <= xa[i];
                br[i] <= xb[i];
                sr[i] <= ns[i];
                cr[i] <= nc[i];
            end
            ovf_r  <= nc[L] ^ ns[L][WIDTH-1] ^ xa[L][WIDTH-1] ^ xb[L][WIDTH-1];
            zero_r <= ns[L] == '0;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench with an arithmetic reference model
module tb_pipelined_addsub;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, sub, out_valid, out_ready, co, ovf, zero;
    logic [31:0] a, b, sum;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b1;
    bit          done;
    exp_t        sb[$];
    exp_t        me;
    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .zero(zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", n, act, exp);
        end
    endtask
    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic v, input logic z);
        exp_t e;
        e.s = s; e.c = c; e.v = v; e.z = z; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction
    // reference: plain wide unsigned/signed arithmetic
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint r;
        logic [31:0] rs;
        logic c;
        rs = s ? x - y : x + y;
        c = s ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 33'h0FFFFFFFF);
        r = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
        return mk(rs, c, r > longint'(32'sh7fffffff) || r < longint'(32'sh80000000), rs == 32'd0);
    endfunction
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual sum=%h required no output", sum);
            end else begin
                me = sb.pop_front();
                chk("sum", sum, me.s);
                chk("co", 32'(co), 32'(me.c));
                chk("ovf", 32'(ovf), 32'(me.v));
                chk("zero", 32'(zero), 32'(me.z));
                if (me.lat) chk("latency", cyc - me.acc, 4);
            end
        end
    end
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input exp_t e);
        int n = 0;
        a = x; b = y; sub = s; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual in_ready=0 required 1");
        end else begin
            e.acc = cyc;
            e.lat = chk_lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
        issue(x, y, s, model(x, y, s));
    endtask
    task automatic send_rand();
        logic [31:0] x, y;
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? x : $urandom;
        send(x, y, 1'($urandom_range(0, 1)));
    endtask
    task automatic wait_drain(input string n);
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(n, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {29'd0, co, ovf, zero}, 0);
        @(posedge clk);
        #1;
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, mk(32'h00000000, 1'b1, 1'b0, 1'b1));
        issue(32'd5, 32'd7, 1'b1, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
        issue(32'd7, 32'd5, 1'b1, mk(32'h00000002, 1'b1, 1'b0, 1'b0));
        issue(32'h80000000, 32'd1, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
        wait_drain("directed_drain");
        repeat (8) send_rand();
        wait_drain("stream_drain");
        chk_lat = 1'b0;
        fork
            repeat (8) send_rand();
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_valid", 32'(out_valid), 1);
                    chk("stall_in_ready", 32'(in_ready), 0);
                    if (sb.size() > 0) chk("stall_sum", sum, sb[0].s);
                    else chk("stall_pending", 0, 1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");
        done = 1'b0;
        fork
            begin
                repeat (150) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 3) != 0;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("random_drain");
        in_valid = 1'b1;
        repeat (3) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("midrst_accept", 32'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 1);
        repeat (8) begin
            chk("midrst_out_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        chk("final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width in bits.
REQ-002 Parameter STAGES, default 4, SHALL set the pipeline depth; WIDTH SHALL be an integer multiple of STAGES, with 1 <= STAGES <= WIDTH.
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mark a, b, sub as valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts an operation this cycle.
REQ-008 a  input  WIDTH  SHALL be operand A.
REQ-009 b  input  WIDTH  SHALL be operand B.
REQ-010 sub  input  1  SHALL select mode: 0 = A+B, 1 = A-B.
REQ-011 out_valid  output  1  SHALL mark the result outputs as valid.
REQ-012 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-013 sum  output  WIDTH  SHALL be the result, modulo 2^WIDTH.
REQ-014 co  output  1  SHALL be the carry out of the MSB (for subtraction: 1 = no borrow).
REQ-015 ovf  output  1  SHALL be the two's-complement signed overflow.
REQ-016 zero  output  1  SHALL be 1 iff sum == 0.

Function
REQ-017 Arithmetic SHALL be computed as A + (B XOR {WIDTH{sub}}) + sub, i.e. the operand is inverted and the carry-in forced to 1 for subtraction.
REQ-018 The datapath SHALL be split into STAGES slices of WIDTH/STAGES bits: stage k adds slice k, with the carry registered from stage k-1, and with the carry-in of stage 0 = sub.
REQ-019 Operand slices not yet consumed and result slices already produced SHALL travel with their operation through the pipeline registers.
REQ-020 An operation SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-021 Define adv = !(out_valid && !out_ready); on each cycle with adv=1 every stage SHALL shift forward by one, and stage 0 SHALL load the accepted operation or a bubble.
REQ-022 When adv=0, all pipeline registers SHALL hold, and the outputs SHALL remain stable.
REQ-023 in_ready SHALL equal adv (combinational from out_valid and out_ready).
REQ-024 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 when no stall occurs.
REQ-025 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-026 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-027 ovf SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-028 co, ovf and zero SHALL be registered with sum and SHALL be valid only when out_valid=1.
REQ-029 Operands SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-030 With STAGES=1, the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-031 While reset=1 at a rising edge, all stage-valid bits SHALL clear, so that out_valid=0 on the next cycle.
REQ-032 After reset, sum, co, ovf and zero SHALL be 0.
REQ-033 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations, and no stale result SHALL appear afterwards.
REQ-035 Inputs presented during reset SHALL be ignored.

Verification (WIDTH=32, STAGES=4)
REQ-036 Reset, then idle: the bench SHALL check out_valid=0, in_ready=1, sum=0.
REQ-037 Addition cases the bench SHALL cover:
- add 0x7FFFFFFF + 0x00000001 -> 4 cycles later sum=0x80000000, co=0, ovf=1, zero=0.
- add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, co=1, ovf=0, zero=1.
REQ-038 Subtraction cases the bench SHALL cover:
- sub 5 - 7 -> sum=0xFFFFFFFE, co=0, ovf=0.
- sub 7 - 5 -> sum=0x00000002, co=1.
- sub 0x80000000 - 1 -> sum=0x7FFFFFFF, ovf=1.
REQ-039 Stream and stall: the bench SHALL stream 8 back-to-back mixed ops with out_ready=1 and check 8 consecutive correct in-order results starting at cycle 4, then drop out_ready for 3 cycles while valid and check that sum holds, in_ready=0, and no result is lost after release.
REQ-040 Reset mid-operation: the bench SHALL accept 3 ops, assert reset for 1 cycle, and check out_valid=0 with none of the 3 results ever appearing.
